alu_stack_ctrl: RTL and testbench

//  Stack-machine sequencer that owns the shared 16-bit signed ALU (combinational, 5-bit function code).

---
 rtl/alu_stack_ctrl.sv | 245 ++++++++++++++++++++++++
 tb/tb_alu_stack_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_stack_ctrl.sv
// -----------------------------------------------------------------------------
// alu_stack_ctrl
//
// Stack-machine sequencer that owns the shared 16-bit signed ALU. It keeps an
// operand stack, accepts PUSH/POP/ALU/CLR commands over a valid/ready
// handshake, drives the ALU operands from the top of the stack and writes the
// ALU result back as the new top of stack.
//
// Optional feature macro: ALU_SEQ_FASTPATH_EN
//   undefined : IDLE -> FETCH -> EXEC -> WB. Operands are registered at
//               acceptance, cutting the stack-read-to-ALU path (latency 4).
//   defined   : IDLE -> EXEC -> WB. Operands are driven combinationally from
//               the stack while busy (latency 3).
//
// Ports
//   clk, rst    clock (rising edge), asynchronous active-high reset
//   cmd_valid   command present
//   cmd_ready   controller can accept a command (IDLE only)
//   cmd_op      0=PUSH 1=POP 2=ALU 3=CLR
//   cmd_f       ALU function code (ALU commands only)
//   cmd_data    PUSH value (signed)
//   alu_a       ALU operand a = TOS
//   alu_b       ALU operand b = TOS-1 (0 for unary codes)
//   alu_f       ALU function code, stable while the operation is in flight
//   alu_s       ALU result, combinational from alu_a/alu_b/alu_f
//   tos         current top of stack (0 when empty)
//   depth       number of entries in use, 0..DEPTH
//   err         sticky overflow/underflow/illegal flag, cleared by CLR/reset
// -----------------------------------------------------------------------------

`ifndef ADD
`define ADD  5'd0
`endif
`ifndef SUB
`define SUB  5'd1
`endif
`ifndef MUL
`define MUL  5'd2
`endif
`ifndef AND
`define AND  5'd3
`endif
`ifndef OR
`define OR   5'd4
`endif
`ifndef XOR
`define XOR  5'd5
`endif
`ifndef NOT
`define NOT  5'd6
`endif
`ifndef BNOT
`define BNOT 5'd7
`endif
`ifndef NEG
`define NEG  5'd8
`endif
`ifndef LT
`define LT   5'd9
`endif
`ifndef EQ
`define EQ   5'd10
`endif
`ifndef SHL
`define SHL  5'd11
`endif
`ifndef ALU_F_MAX
`define ALU_F_MAX 5'd11
`endif

module alu_stack_ctrl #(
    parameter int DEPTH = 8,
    parameter int PTR_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [4:0]       cmd_f,
    input  logic [15:0]      cmd_data,
    output logic [15:0]      alu_a,
    output logic [15:0]      alu_b,
    output logic [4:0]       alu_f,
    input  logic [15:0]      alu_s,
    output logic [15:0]      tos,
    output logic [PTR_W:0]   depth,
    output logic             err
);

    localparam logic [1:0] OP_PUSH = 2'd0;
    localparam logic [1:0] OP_POP  = 2'd1;
    localparam logic [1:0] OP_ALU  = 2'd2;
    localparam logic [1:0] OP_CLR  = 2'd3;

    localparam logic [PTR_W:0]   SP1  = (PTR_W+1)'(1);
    localparam logic [PTR_W:0]   SP2  = (PTR_W+1)'(2);
    localparam logic [PTR_W:0]   FULL = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W-1:0] I1   = PTR_W'(1);
    localparam logic [PTR_W-1:0] I2   = PTR_W'(2);

    typedef enum logic [1:0] {IDLE, FETCH, EXEC, WB} state_t;

`ifdef ALU_SEQ_FASTPATH_EN
    localparam state_t FIRST = EXEC;
`else
    localparam state_t FIRST = FETCH;
`endif

    state_t            state, state_d;
    logic [PTR_W:0]    sp, sp_d;
    logic              err_d;
    logic              push_we, wb_we, alu_go;
    logic              uq;          // in-flight op is unary
    logic [4:0]        f_q;
    logic signed [15:0] stack [DEPTH];
    logic signed [15:0] res_q;
    logic [PTR_W-1:0]  idx_sp, idx_m1, idx_m2, wb_idx;
    logic signed [15:0] rd_a, rd_b, wb_val;
    logic              wb_bad;

    function automatic logic is_unary(input logic [4:0] f);
        return (f == `NEG) || (f == `BNOT) || (f == `NOT);
    endfunction

    function automatic logic [PTR_W:0] n_operands(input logic [4:0] f);
        return is_unary(f) ? SP1 : SP2;
    endfunction

    // Undefined codes, or an X/Z result from the ALU, write 0 and flag err.
    function automatic logic result_bad(input logic [4:0] f, input logic signed [15:0] r);
        return (f > `ALU_F_MAX) || $isunknown(r);
    endfunction

    assign idx_sp = sp[PTR_W-1:0];
    assign idx_m1 = idx_sp - I1;
    assign idx_m2 = idx_sp - I2;
    assign rd_a   = stack[idx_m1];
    assign rd_b   = stack[idx_m2];

    assign tos   = (sp == '0) ? 16'd0 : rd_a;
    assign depth = sp;
    assign alu_f = f_q;

    assign wb_bad = result_bad(f_q, res_q);
    assign wb_val = wb_bad ? 16'sd0 : res_q;
    // Unary ops overwrite TOS in place; binary ops land one slot lower.
    assign wb_idx = uq ? idx_m1 : idx_m2;

`ifdef ALU_SEQ_FASTPATH_EN
    assign alu_a = (state == IDLE) ? 16'd0 : rd_a;
    assign alu_b = (state == IDLE || uq) ? 16'd0 : rd_b;
`else
    logic [15:0] a_q, b_q;
    assign alu_a = a_q;
    assign alu_b = b_q;
`endif

    always_comb begin
        state_d   = state;
        sp_d      = sp;
        err_d     = err;
        cmd_ready = 1'b0;
        push_we   = 1'b0;
        wb_we     = 1'b0;
        alu_go    = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    case (cmd_op)
                        OP_PUSH: begin
                            if (sp < FULL) begin
                                push_we = !rst;
                                sp_d    = sp + SP1;
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                        OP_POP: begin
                            if (sp != '0) sp_d = sp - SP1;
                            else          err_d = 1'b1;
                        end
                        OP_ALU: begin
                            if (sp < n_operands(cmd_f)) begin
                                err_d = 1'b1;
                            end else begin
                                alu_go  = 1'b1;
                                state_d = FIRST;
                            end
                        end
                        OP_CLR: begin
                            sp_d  = '0;
                            err_d = 1'b0;
                        end
                    endcase
                end
            end
            FETCH: state_d = EXEC;
            EXEC:  state_d = WB;
            WB: begin
                wb_we   = 1'b1;
                sp_d    = uq ? sp : sp - SP1;
                if (wb_bad) err_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and operand registers; reset aborts any in-flight operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            sp    <= '0;
            err   <= 1'b0;
            f_q   <= '0;
            uq    <= 1'b0;
`ifndef ALU_SEQ_FASTPATH_EN
            a_q   <= '0;
            b_q   <= '0;
`endif
        end else begin
            state <= state_d;
            sp    <= sp_d;
            err   <= err_d;
            if (alu_go) begin
                f_q <= cmd_f;
                uq  <= is_unary(cmd_f);
`ifndef ALU_SEQ_FASTPATH_EN
                a_q <= rd_a;
                b_q <= is_unary(cmd_f) ? 16'd0 : rd_b;
`endif
            end
        end
    end

    // EXEC -> WB boundary: capture ALU result. WB -> IDLE boundary: stack write.
    always_ff @(posedge clk) begin
        if (state == EXEC) res_q <= alu_s;
        if (push_we)      stack[idx_sp] <= cmd_data;
        else if (wb_we)   stack[wb_idx] <= wb_val;
    end

endmodule

// File: tb/tb_alu_stack_ctrl.sv
// Directed bench for alu_stack_ctrl with a behavioural ALU model.

`ifndef ADD
`define ADD  5'd0
`endif
`ifndef SUB
`define SUB  5'd1
`endif
`ifndef MUL
`define MUL  5'd2
`endif
`ifndef AND
`define AND  5'd3
`endif
`ifndef OR
`define OR   5'd4
`endif
`ifndef XOR
`define XOR  5'd5
`endif
`ifndef NOT
`define NOT  5'd6
`endif
`ifndef BNOT
`define BNOT 5'd7
`endif
`ifndef NEG
`define NEG  5'd8
`endif
`ifndef LT
`define LT   5'd9
`endif
`ifndef EQ
`define EQ   5'd10
`endif
`ifndef SHL
`define SHL  5'd11
`endif

module tb_alu_stack_ctrl;

    localparam logic [1:0] OP_PUSH = 2'd0;
    localparam logic [1:0] OP_POP  = 2'd1;
    localparam logic [1:0] OP_ALU  = 2'd2;
    localparam logic [1:0] OP_CLR  = 2'd3;

`ifdef ALU_SEQ_FASTPATH_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 4;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [4:0]  cmd_f;
    logic [15:0] cmd_data;
    logic [15:0] alu_a, alu_b, alu_s, tos;
    logic [4:0]  alu_f;
    logic [3:0]  depth;
    logic        err;

    int checks   = 0;
    int failures = 0;

    alu_stack_ctrl #(.DEPTH(8), .PTR_W(3)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_f(cmd_f), .cmd_data(cmd_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f), .alu_s(alu_s),
        .tos(tos), .depth(depth), .err(err)
    );

    always #5 clk = ~clk;

    // Behavioural ALU: a = TOS, b = TOS-1; SUB is a - b.
    always_comb begin
        case (alu_f)
            `ADD:  alu_s = alu_a + alu_b;
            `SUB:  alu_s = alu_a - alu_b;
            `MUL:  alu_s = alu_a * alu_b;
            `AND:  alu_s = alu_a & alu_b;
            `OR:   alu_s = alu_a | alu_b;
            `XOR:  alu_s = alu_a ^ alu_b;
            `NOT:  alu_s = {15'd0, (alu_a == 16'd0)};
            `BNOT: alu_s = ~alu_a;
            `NEG:  alu_s = 16'd0 - alu_a;
            `LT:   alu_s = {15'd0, ($signed(alu_a) < $signed(alu_b))};
            `EQ:   alu_s = {15'd0, (alu_a == alu_b)};
            `SHL:  alu_s = alu_a << alu_b[3:0];
            default: alu_s = 'x;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one command at a negedge, wait for acceptance, then scramble inputs.
    task automatic issue(input logic [1:0] op, input logic [4:0] f, input logic [15:0] data,
                         input bit hold);
        int guard;
        guard = 0;
        @(negedge clk);
        while (cmd_ready !== 1'b1 && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        if (cmd_ready !== 1'b1) chk("ready_timeout", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_f     = f;
        cmd_data  = data;
        @(posedge clk);
        #1;
        if (!hold) cmd_valid = 1'b0;
        cmd_op   = OP_PUSH;
        cmd_f    = 5'd31;
        cmd_data = 16'hDEAD;
    endtask

    // Full ALU sequence with operand, busy-window and latency checks.
    task automatic alu_seq(input logic [4:0] f, input logic [15:0] ea, input logic [15:0] eb,
                           input logic [15:0] old_tos, input logic [15:0] new_tos,
                           input string tag, input bit hold);
        issue(OP_ALU, f, 16'd0, hold);
        @(negedge clk);
        chk({tag, "_busy1"}, 32'(cmd_ready), 32'd0);
        chk({tag, "_alu_a"}, 32'(alu_a), 32'(ea));
        chk({tag, "_alu_b"}, 32'(alu_b), 32'(eb));
        chk({tag, "_alu_f"}, 32'(alu_f), 32'(f));
        repeat (LAT - 2) @(posedge clk);
        @(negedge clk);
        chk({tag, "_wb_busy"}, 32'(cmd_ready), 32'd0);
        chk({tag, "_wb_tos_old"}, 32'(tos), 32'(old_tos));
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_tos"}, 32'(tos), 32'(new_tos));
        chk({tag, "_ready"}, 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = OP_PUSH; cmd_f = '0; cmd_data = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(cmd_ready), 32'd1);
        chk("rst_depth", 32'(depth), 32'd0);
        chk("rst_tos",   32'(tos),   32'd0);
        chk("rst_err",   32'(err),   32'd0);
        chk("rst_alu_a", 32'(alu_a), 32'd0);
        chk("rst_alu_b", 32'(alu_b), 32'd0);
        chk("rst_alu_f", 32'(alu_f), 32'd0);
        rst = 1'b0;

        // 1: 5, 3, SUB -> 3 - 5 = -2
        issue(OP_PUSH, 5'd0, 16'd5, 1'b0);
        issue(OP_PUSH, 5'd0, 16'd3, 1'b0);
        @(negedge clk);
        chk("s1_depth2", 32'(depth), 32'd2);
        chk("s1_tos3",   32'(tos),   32'd3);
        alu_seq(`SUB, 16'd3, 16'd5, 16'd3, 16'hFFFE, "s1_sub", 1'b0);
        chk("s1_depth", 32'(depth), 32'd1);
        chk("s1_err",   32'(err),   32'd0);

        // 2: -7, NEG -> 7, unary keeps depth, alu_b forced to 0
        issue(OP_PUSH, 5'd0, 16'hFFF9, 1'b0);
        alu_seq(`NEG, 16'hFFF9, 16'd0, 16'hFFF9, 16'd7, "s2_neg", 1'b0);
        chk("s2_depth", 32'(depth), 32'd2);
        chk("s2_err",   32'(err),   32'd0);

        // 3: fill, overflow, clear
        issue(OP_CLR, 5'd0, 16'd0, 1'b0);
        for (int i = 0; i < 8; i++) issue(OP_PUSH, 5'd0, 16'(10 + i), 1'b0);
        @(negedge clk);
        chk("s3_full_depth", 32'(depth), 32'd8);
        chk("s3_full_tos",   32'(tos),   32'h11);
        chk("s3_full_err",   32'(err),   32'd0);
        issue(OP_PUSH, 5'd0, 16'd1, 1'b0);
        @(negedge clk);
        chk("s3_ovf_err",   32'(err),   32'd1);
        chk("s3_ovf_depth", 32'(depth), 32'd8);
        chk("s3_ovf_tos",   32'(tos),   32'h11);
        issue(OP_CLR, 5'd0, 16'd0, 1'b0);
        @(negedge clk);
        chk("s3_clr_depth", 32'(depth), 32'd0);
        chk("s3_clr_err",   32'(err),   32'd0);
        chk("s3_clr_tos",   32'(tos),   32'd0);

        // 4: underflow on POP, binary ALU with one operand
        issue(OP_POP, 5'd0, 16'd0, 1'b0);
        @(negedge clk);
        chk("s4_pop_err",   32'(err),   32'd1);
        chk("s4_pop_depth", 32'(depth), 32'd0);
        issue(OP_PUSH, 5'd0, 16'd1, 1'b0);
        issue(OP_ALU, `ADD, 16'd0, 1'b0);
        @(negedge clk);
        chk("s4_alu_noentry", 32'(cmd_ready), 32'd1);
        chk("s4_alu_err",     32'(err),       32'd1);
        chk("s4_alu_depth",   32'(depth),     32'd1);
        chk("s4_alu_tos",     32'(tos),       32'd1);
        issue(OP_CLR, 5'd0, 16'd0, 1'b0);

        // 5: wrap, with cmd_valid held high across the busy window
        issue(OP_PUSH, 5'd0, 16'h7FFF, 1'b0);
        issue(OP_PUSH, 5'd0, 16'd1, 1'b0);
        alu_seq(`ADD, 16'd1, 16'h7FFF, 16'd1, 16'h8000, "s5_add", 1'b1);
        chk("s5_depth", 32'(depth), 32'd1);
        cmd_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("s5_no_extra_depth", 32'(depth), 32'd1);
        chk("s5_no_extra_tos",   32'(tos),   32'h8000);
        chk("s5_err",            32'(err),   32'd0);

        // Undefined function code: result 0, err set
        issue(OP_CLR, 5'd0, 16'd0, 1'b0);
        issue(OP_PUSH, 5'd0, 16'd2, 1'b0);
        issue(OP_PUSH, 5'd0, 16'd3, 1'b0);
        alu_seq(5'd20, 16'd3, 16'd2, 16'd3, 16'd0, "ill", 1'b0);
        chk("ill_err",   32'(err),   32'd1);
        chk("ill_depth", 32'(depth), 32'd1);

        // 6: reset during EXEC of MUL
        issue(OP_CLR, 5'd0, 16'd0, 1'b0);
        issue(OP_PUSH, 5'd0, 16'd3, 1'b0);
        issue(OP_PUSH, 5'd0, 16'd4, 1'b0);
        issue(OP_ALU, `MUL, 16'd0, 1'b0);
        @(negedge clk);
`ifndef ALU_SEQ_FASTPATH_EN
        @(posedge clk);
        @(negedge clk);
`endif
        chk("s6_in_exec", 32'(cmd_ready), 32'd0);
        rst = 1'b1;
        #1;
        chk("s6_async_depth", 32'(depth),     32'd0);
        chk("s6_async_ready", 32'(cmd_ready), 32'd1);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("s6_depth", 32'(depth),     32'd0);
        chk("s6_ready", 32'(cmd_ready), 32'd1);
        chk("s6_alu_a", 32'(alu_a),     32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("s6_no_wb_depth", 32'(depth), 32'd0);
        chk("s6_no_wb_tos",   32'(tos),   32'd0);
        issue(OP_PUSH, 5'd0, 16'd9, 1'b0);
        @(negedge clk);
        chk("s6_push_tos",   32'(tos),   32'd9);
        chk("s6_push_depth", 32'(depth), 32'd1);

        // Binary op after reset recovery
        issue(OP_PUSH, 5'd0, 16'd6, 1'b0);
        alu_seq(`MUL, 16'd6, 16'd9, 16'd6, 16'd54, "post_mul", 1'b0);
        chk("post_mul_depth", 32'(depth), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
